// File: rtl/nv_ram_rws_param.sv
// ---------------------------------------------------------------------------
// nv_ram_rws_param
//   Parametrised 1R1W RAM model with a registered read address. Width and
//   depth are free (depth need not be a power of two). After reset the array
//   can be zero-filled one word per cycle; reads and writes are accepted only
//   once that fill is complete. An optional output register adds one cycle of
//   read latency. dout_vld pulses once per accepted read and has no
//   backpressure.
//
// Ports
//   clk            in   1      clock
//   rstn           in   1      reset, synchronous, active-low
//   ra             in   AW     read address
//   re             in   1      read enable
//   dout           out  DW     read data
//   dout_vld       out  1      dout holds data for a read accepted OREG+1 cycles earlier
//   wa             in   AW     write address
//   we             in   1      write enable
//   di             in   DW     write data
//   init_done      out  1      high once the zero-fill is complete
//   pwrbus_ram_pd  in   32     power-bus control, unused by this model
// ---------------------------------------------------------------------------
module nv_ram_rws_param #(
  parameter int DW       = 32,
  parameter int AW       = 6,
  parameter int DEPTH    = 64,
  parameter int OREG     = 0,
  parameter int INIT_CLR = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  output logic          init_done,
  input  logic [31:0]   pwrbus_ram_pd
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int              AW1       = AW + 1;
  // Depth widened by one bit so an address can be range-checked against it.
  localparam logic [AW:0]     DEPTH_W   = AW1'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam state_e          RST_STATE = (INIT_CLR != 0) ? ST_INIT : ST_READY;
  localparam logic            RST_DONE  = (INIT_CLR != 0) ? 1'b0 : 1'b1;

  logic [DW-1:0] mem [0:DEPTH-1];

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_vld_q, rd_vld_d;

  logic          ready_s;
  logic          rd_acc_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_wa_s;
  logic [DW-1:0] mem_wd_s;
  logic [DW-1:0] rd_data_s;

  logic          unused_pwrbus_s;

  assign unused_pwrbus_s = ^pwrbus_ram_pd;
  assign ready_s         = (state_q == ST_READY);
  assign rd_acc_s        = re & ready_s;
  assign init_done       = init_done_q;

  // Fill sequencer: walk the counter through every word, then park in READY.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
          init_done_d = 1'b0;
        end
      end
      ST_READY: begin
        state_d     = ST_READY;
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = RST_STATE;
        cnt_d       = {AW{1'b0}};
        init_done_d = RST_DONE;
      end
    endcase
  end

  // Write port mux: the fill owns the array until READY; user writes beyond
  // DEPTH are dropped rather than aliased onto a lower word.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = {AW{1'b0}};
    mem_wd_s = {DW{1'b0}};
    if (!rstn) begin
      mem_we_s = 1'b0;
    end else if (state_q == ST_INIT) begin
      mem_we_s = 1'b1;
      mem_wa_s = cnt_q;
      mem_wd_s = {DW{1'b0}};
    end else if (we && ({1'b0, wa} < DEPTH_W)) begin
      mem_we_s = 1'b1;
      mem_wa_s = wa;
      mem_wd_s = di;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Read address capture and first-stage valid.
  always_comb begin
    rd_vld_d = rd_acc_s;
    if (rd_acc_s) begin
      rd_addr_d = ra;
    end else begin
      rd_addr_d = rd_addr_q;
    end
  end

  // Array read; out-of-range addresses read as zero.
  always_comb begin
    if ({1'b0, rd_addr_q} < DEPTH_W) begin
      rd_data_s = mem[rd_addr_q];
    end else begin
      rd_data_s = {DW{1'b0}};
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_wa_s] <= mem_wd_s;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= RST_STATE;
      cnt_q       <= {AW{1'b0}};
      init_done_q <= RST_DONE;
      rd_addr_q   <= {AW{1'b0}};
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] dout_q, dout_d;
      logic          dout_vld_q, dout_vld_d;

      // Output stage: capture the word addressed one cycle ago; a write at
      // this same edge is not seen because the array updates concurrently.
      always_comb begin
        dout_vld_d = rd_vld_q;
        if (rd_vld_q) begin
          dout_d = rd_data_s;
        end else begin
          dout_d = dout_q;
        end
      end

      // Output stage registers.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          dout_q     <= {DW{1'b0}};
          dout_vld_q <= 1'b0;
        end else begin
          dout_q     <= dout_d;
          dout_vld_q <= dout_vld_d;
        end
      end

      assign dout     = dout_q;
      assign dout_vld = dout_vld_q;
    end else begin : g_noreg
      // Data follows the array combinationally, so later writes to the held
      // address show up on dout.
      assign dout     = rd_data_s;
      assign dout_vld = rd_vld_q;
    end
  endgenerate

endmodule
